fetch_ras: RTL and testbench

- Return address stack (RAS) for fetch 1.
- Consumes the per-slot RAS control code produced by the branch decoder.
- Supplies the top-of-stack return address that the decoder uses as the predicted target for RET and JSR_COROUTINE.
- Circular register stack: push/pop/pop-push with saturating occupancy. Optional checkpoint/recovery restores state after a fetch redirect.

---
 rtl/fetch_ras.sv | 120 ++++++++++++
 tb/tb_fetch_ras.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ras.sv
// fetch_ras: return address stack for fetch 1.
// A circular stack of return addresses. The decoder reads the top entry as the
// predicted target for RET and JSR_COROUTINE, and applies a push, pop or
// pop-then-push code each cycle. Occupancy saturates at DEPTH.
// Optional feature macro: RAS_CKPT_EN. When it is defined, the recover_* ports
// exist and let fetch restore a checkpointed TOS, occupancy and top entry after
// a redirect.
module fetch_ras #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             ras_vld_i,
  input  logic [1:0]       ras_ctl_i,
  input  logic [63:0]      pc_i,
  output logic [63:0]      ras_data_o,
  output logic             ras_empty_o,
  output logic             ras_full_o,
  output logic [PTR_W-1:0] ras_tos_o,
  output logic [PTR_W:0]   ras_cnt_o
`ifdef RAS_CKPT_EN
  ,
  input  logic             recover_i,
  input  logic [PTR_W-1:0] recover_tos_i,
  input  logic [PTR_W:0]   recover_cnt_i,
  input  logic [63:0]      recover_data_i
`endif
);

  localparam logic [1:0]       CTL_PUSH = 2'b01;
  localparam logic [1:0]       CTL_POP  = 2'b10;
  localparam logic [1:0]       CTL_PP   = 2'b11;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] TOS_RST  = PTR_W'(DEPTH-1);

  logic [63:0]      mem_q [DEPTH];
  logic [63:0]      mem_d [DEPTH];
  logic [PTR_W-1:0] tos_q, tos_d;
  logic [PTR_W:0]   cnt_q, cnt_d;

  logic             upd;
  logic [63:0]      ret_addr;
  logic [PTR_W-1:0] tos_inc, tos_dec;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [63:0]      wr_data;

  assign upd      = ras_vld_i & ~stall_i;
  assign ret_addr = pc_i + 64'd4;
  // Pointer width equals log2(DEPTH), so plain +/-1 wraps modulo DEPTH.
  assign tos_inc  = tos_q + PTR_W'(1);
  assign tos_dec  = tos_q - PTR_W'(1);

  // Next-state for pointer, occupancy and the single entry write this cycle.
  always_comb begin
    tos_d   = tos_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_idx  = tos_inc;
    wr_data = ret_addr;
    if (upd) begin
      // Pop-then-push on an empty stack degrades to a plain push.
      if (ras_ctl_i == CTL_PUSH || (ras_ctl_i == CTL_PP && cnt_q == '0)) begin
        wr_en  = 1'b1;
        wr_idx = tos_inc;
        tos_d  = tos_inc;
        // At full the oldest entry is overwritten; occupancy stays saturated.
        cnt_d  = (cnt_q == FULL_CNT) ? cnt_q : cnt_q + (PTR_W+1)'(1);
      end else if (ras_ctl_i == CTL_POP) begin
        // Underflow is ignored; entries are never cleared on pop.
        if (cnt_q != '0) begin
          tos_d = tos_dec;
          cnt_d = cnt_q - (PTR_W+1)'(1);
        end
      end else if (ras_ctl_i == CTL_PP) begin
        wr_en  = 1'b1;
        wr_idx = tos_q;
      end
    end
`ifdef RAS_CKPT_EN
    // Recovery overrides stall and any stack op in the same cycle.
    if (recover_i) begin
      tos_d   = recover_tos_i;
      cnt_d   = (recover_cnt_i > FULL_CNT) ? FULL_CNT : recover_cnt_i;
      wr_en   = 1'b1;
      wr_idx  = recover_tos_i;
      wr_data = recover_data_i;
    end
`endif
  end

  // Entry array next state: at most one entry changes per cycle.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_idx] = wr_data;
  end

  // State registers with immediate clear on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      tos_q <= TOS_RST;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      tos_q <= tos_d;
      cnt_q <= cnt_d;
    end
  end

  // Registered state, combinational read: decoder sees the pre-update TOS.
  assign ras_data_o  = mem_q[tos_q];
  assign ras_empty_o = (cnt_q == '0);
  assign ras_full_o  = (cnt_q == FULL_CNT);
  assign ras_tos_o   = tos_q;
  assign ras_cnt_o   = cnt_q;

endmodule

// File: tb/tb_fetch_ras.sv
// Self-checking bench for fetch_ras (DEPTH = 8). Each driven op updates a
// reference stack and pushes the expected post-edge state to a scoreboard
// queue; after the edge the entry is popped and compared against the outputs.
module tb_fetch_ras;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, ras_vld_i;
  logic [1:0]  ras_ctl_i;
  logic [63:0] pc_i;
  logic [63:0] ras_data_o;
  logic        ras_empty_o, ras_full_o;
  logic [2:0]  ras_tos_o;
  logic [3:0]  ras_cnt_o;
  logic        recover_i      = 1'b0;
  logic [2:0]  recover_tos_i  = '0;
  logic [3:0]  recover_cnt_i  = '0;
  logic [63:0] recover_data_i = '0;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  cnt;
    logic [2:0]  tos;
  } exp_t;
  exp_t sb_q[$];

  logic [63:0] m_mem [8];
  int          m_tos, m_cnt;

  fetch_ras #(.DEPTH(8), .PTR_W(3)) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .ras_vld_i(ras_vld_i),
    .ras_ctl_i(ras_ctl_i), .pc_i(pc_i), .ras_data_o(ras_data_o),
    .ras_empty_o(ras_empty_o), .ras_full_o(ras_full_o),
    .ras_tos_o(ras_tos_o), .ras_cnt_o(ras_cnt_o)
`ifdef RAS_CKPT_EN
    , .recover_i(recover_i), .recover_tos_i(recover_tos_i),
    .recover_cnt_i(recover_cnt_i), .recover_data_i(recover_data_i)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = '0;
    m_tos = 7;
    m_cnt = 0;
  endtask

  task automatic model_push(input logic [63:0] pc);
    m_tos = (m_tos + 1) % 8;
    m_mem[m_tos] = pc + 64'd4;
    if (m_cnt < 8) m_cnt++;
  endtask

  task automatic model_op(input logic vld, input logic stall, input logic [1:0] ctl,
                          input logic [63:0] pc);
    if (recover_i) begin
      m_tos = int'(recover_tos_i);
      m_cnt = (recover_cnt_i > 4'd8) ? 8 : int'(recover_cnt_i);
      m_mem[m_tos] = recover_data_i;
    end else if (vld && !stall) begin
      case (ctl)
        2'b01: model_push(pc);
        2'b10: if (m_cnt > 0) begin m_tos = (m_tos + 7) % 8; m_cnt--; end
        2'b11: if (m_cnt > 0) m_mem[m_tos] = pc + 64'd4; else model_push(pc);
        default: ;
      endcase
    end
  endtask

  function automatic exp_t model_state();
    exp_t e;
    e.data = m_mem[m_tos];
    e.cnt  = 4'(m_cnt);
    e.tos  = 3'(m_tos);
    return e;
  endfunction

  // Drive one op, let one edge pass, then score the DUT outputs.
  task automatic step(input string tag, input logic vld, input logic stall,
                      input logic [1:0] ctl, input logic [63:0] pc);
    exp_t e;
    ras_vld_i = vld; stall_i = stall; ras_ctl_i = ctl; pc_i = pc;
    model_op(vld, stall, ctl, pc);
    sb_q.push_back(model_state());
    @(posedge clk);
    #1;
    ras_vld_i = 1'b0; stall_i = 1'b0; ras_ctl_i = 2'b00; recover_i = 1'b0;
    e = sb_q.pop_front();
    chk({tag, ".data"},  ras_data_o,  e.data);
    chk({tag, ".cnt"},   ras_cnt_o,   64'(e.cnt));
    chk({tag, ".tos"},   ras_tos_o,   64'(e.tos));
    chk({tag, ".empty"}, ras_empty_o, 64'(e.cnt == 4'd0));
    chk({tag, ".full"},  ras_full_o,  64'(e.cnt == 4'd8));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    stall_i = 1'b0; ras_vld_i = 1'b0; ras_ctl_i = 2'b00; pc_i = '0;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst.data",  ras_data_o,  64'h0);
    chk("rst.empty", ras_empty_o, 64'h1);
    chk("rst.full",  ras_full_o,  64'h0);
    chk("rst.tos",   ras_tos_o,   64'h7);
    chk("rst.cnt",   ras_cnt_o,   64'h0);
    @(negedge clk);
    reset = 1'b0;

    // Basic push/push/pop/pop.
    step("push1", 1, 0, 2'b01, 64'h1000); chk("push1.v", ras_data_o, 64'h1004);
    step("push2", 1, 0, 2'b01, 64'h2000); chk("push2.v", ras_data_o, 64'h2004);
    step("pop1",  1, 0, 2'b10, 64'h0);    chk("pop1.v",  ras_data_o, 64'h1004);
    step("pop2",  1, 0, 2'b10, 64'h0);    chk("pop2.e",  ras_empty_o, 64'h1);

    // Underflow and pop-then-push on empty.
    do_reset();
    step("upop", 1, 0, 2'b10, 64'h0);
    chk("upop.tos", ras_tos_o, 64'h7); chk("upop.data", ras_data_o, 64'h0);
    step("pp_empty", 1, 0, 2'b11, 64'h40);
    chk("pp_empty.data", ras_data_o, 64'h44); chk("pp_empty.cnt", ras_cnt_o, 64'h1);

    // Stall and invalid gate updates; pop-then-push replaces TOS.
    step("push70", 1, 0, 2'b01, 64'h70);
    step("stall",  1, 1, 2'b01, 64'h500); chk("stall.data", ras_data_o, 64'h74);
    step("novld",  0, 0, 2'b01, 64'h500); chk("novld.cnt",  ras_cnt_o,  64'h2);
    step("pp600",  1, 0, 2'b11, 64'h600);
    chk("pp600.data", ras_data_o, 64'h604); chk("pp600.cnt", ras_cnt_o, 64'h2);

    // Overflow: 10 pushes into 8 entries, then 8 pops.
    do_reset();
    for (int k = 1; k <= 10; k++) step("ovf_push", 1, 0, 2'b01, 64'(k) * 64'h100);
    chk("ovf.full", ras_full_o, 64'h1); chk("ovf.cnt", ras_cnt_o, 64'h8);
    chk("ovf.data", ras_data_o, 64'hA04);
    for (int k = 0; k < 8; k++) begin
      chk("walk.data", ras_data_o, 64'hA04 - 64'(k) * 64'h100);
      step("walk_pop", 1, 0, 2'b10, 64'h0);
    end
    chk("walk.cnt", ras_cnt_o, 64'h0);

    // Asynchronous reset mid-run after three pushes.
    for (int k = 1; k <= 3; k++) step("pre_rst", 1, 0, 2'b01, 64'(k) * 64'h10);
    #1;
    reset = 1'b1;
    #1;
    chk("arst.data",  ras_data_o,  64'h0);
    chk("arst.cnt",   ras_cnt_o,   64'h0);
    chk("arst.tos",   ras_tos_o,   64'h7);
    chk("arst.empty", ras_empty_o, 64'h1);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

`ifdef RAS_CKPT_EN
    // Checkpoint, push two more, then recover alongside a stalled push.
    step("ck1", 1, 0, 2'b01, 64'h1000);
    step("ck2", 1, 0, 2'b01, 64'h2000);
    step("ck3", 1, 0, 2'b01, 64'h3000);
    recover_tos_i = ras_tos_o; recover_cnt_i = ras_cnt_o; recover_data_i = ras_data_o;
    chk("ck.tos", recover_tos_i, 64'h2); chk("ck.data", recover_data_i, 64'h3004);
    step("ck4", 1, 0, 2'b01, 64'h4000);
    step("ck5", 1, 0, 2'b01, 64'h5000);
    recover_i = 1'b1;
    step("rec", 1, 1, 2'b01, 64'h9000);
    chk("rec.tos", ras_tos_o, 64'h2); chk("rec.cnt", ras_cnt_o, 64'h3);
    chk("rec.data", ras_data_o, 64'h3004);
    recover_i = 1'b1; recover_tos_i = 3'd5; recover_cnt_i = 4'd15; recover_data_i = 64'hBEEF;
    step("rec_clamp", 0, 0, 2'b00, 64'h0);
    chk("rec_clamp.cnt", ras_cnt_o, 64'h8);
`endif

    // Random mix scored against the reference stack.
    for (int i = 0; i < 200; i++)
      step("rand", 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
           2'($urandom_range(0, 3)), {32'h0, $urandom} & 64'hFFFF_FFFC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
